// File: rtl/lfa_adc_reader.sv
`default_nettype none
// lfa_adc_reader -- sweeps left/centre/right line sensors on an ADC128S022.
// Rev 1.0
module lfa_adc_reader #(
  parameter logic [2:0]  CH_LEFT    = 3'd3,
  parameter logic [2:0]  CH_CENTER  = 3'd4,
  parameter logic [2:0]  CH_RIGHT   = 3'd5,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_sck,
  output logic        adc_din,
  output logic [11:0] ld1,
  output logic [11:0] ld2,
  output logic [11:0] ld3,
  output logic        data_valid
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  localparam logic [1:0] SEL_LEFT   = 2'd0;
  localparam logic [1:0] SEL_CENTER = 2'd1;
  localparam logic [1:0] SEL_RIGHT  = 2'd2;

  typedef enum logic {ST_GAP, ST_FRAME} state_t;

  state_t      state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [4:0]  cyc_q, cyc_d;
  logic [1:0]  sel_q, sel_d;
  logic        discard_q, discard_d;
  logic [15:0] shift_q, shift_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic        din_q, din_d;
  logic [11:0] ld1_q, ld1_d, ld2_q, ld2_d, ld3_q, ld3_d;
  logic        dv_q, dv_d;
  logic [2:0]  addr;
  logic [15:0] addr_word;
  logic [15:0] rx_word;

  always_comb begin
    case (sel_q)
      SEL_CENTER: addr = CH_CENTER;
      SEL_RIGHT:  addr = CH_RIGHT;
      default:    addr = CH_LEFT;
    endcase
    addr_word = {2'b00, addr, 11'b0};
  end

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    cyc_d     = cyc_q;
    sel_d     = sel_q;
    discard_d = discard_q;
    shift_d   = shift_q;
    ld1_d     = ld1_q;
    ld2_d     = ld2_q;
    ld3_d     = ld3_q;
    dv_d      = 1'b0;
    rx_word   = {shift_q[14:0], adc_dout};

    case (state_q)
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (en) begin
            state_d = ST_FRAME;
            cyc_d   = 5'd0;
            gap_d   = '0;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_FRAME: begin
        cyc_d = cyc_q + 5'd1;
        if (cyc_q[0]) shift_d = rx_word;
        if (cyc_q == 5'd31) begin
          state_d   = ST_GAP;
          gap_d     = '0;
          discard_d = 1'b0;
          sel_d     = (sel_q == SEL_RIGHT) ? SEL_LEFT : sel_q + 2'd1;
          // The ADC answers with the channel addressed one frame earlier.
          if (!discard_q) begin
            case (sel_q)
              SEL_CENTER: ld1_d = rx_word[11:0];
              SEL_RIGHT:  ld2_d = rx_word[11:0];
              SEL_LEFT: begin
                ld3_d = rx_word[11:0];
                dv_d  = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_d = ST_GAP;
    endcase

    cs_n_d = (state_d != ST_FRAME);
    sck_d  = (state_d == ST_FRAME) ? cyc_d[0] : 1'b1;
    din_d  = (state_d == ST_FRAME) ? addr_word[~cyc_d[4:1]] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_GAP;
      gap_q     <= '0;
      cyc_q     <= 5'd0;
      sel_q     <= SEL_LEFT;
      discard_q <= 1'b1;
      shift_q   <= 16'h0000;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b1;
      din_q     <= 1'b0;
      ld1_q     <= 12'h000;
      ld2_q     <= 12'h000;
      ld3_q     <= 12'h000;
      dv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      cyc_q     <= cyc_d;
      sel_q     <= sel_d;
      discard_q <= discard_d;
      shift_q   <= shift_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
      din_q     <= din_d;
      ld1_q     <= ld1_d;
      ld2_q     <= ld2_d;
      ld3_q     <= ld3_d;
      dv_q      <= dv_d;
    end
  end

  assign adc_cs_n   = cs_n_q;
  assign adc_sck    = sck_q;
  assign adc_din    = din_q;
  assign ld1        = ld1_q;
  assign ld2        = ld2_q;
  assign ld3        = ld3_q;
  assign data_valid = dv_q;

endmodule
`default_nettype wire
